// File: rtl/leaf_elim_pkg.sv
// Shared mode encodings, FSM state type and lattice neighbour helper for the
// iterative leaf eliminator.
package leaf_elim_pkg;

  localparam logic [1:0] MODE_DOWN = 2'd0;
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } elimState_t;

  // Node whose subset differs from 'node' only in variable 'bitPos'.
  function automatic int neighbourIdx(input int node, input int bitPos);
    return node ^ (1 << bitPos);
  endfunction

endpackage

// File: rtl/leaf_elim_pass.sv
// One combinational leaf-elimination pass over the whole lattice node mask.
// dirUp=0 removes downward leaves, dirUp=1 removes upward leaves.
module leaf_elim_pass
  import leaf_elim_pkg::*;
#(
  parameter int VAR_COUNT = 7,
  localparam int W = 2 ** VAR_COUNT
) (
  input  logic [W-1:0] graphIn,
  input  logic         dirUp,
  output logic [W-1:0] graphOut,
  output logic         changed
);

  logic [W-1:0] removeMask;

  // Bottom and top of the lattice are never eliminated.
  assign removeMask[0]   = 1'b0;
  assign removeMask[W-1] = 1'b0;

  for (genvar i = 1; i < W - 1; i++) begin : gNode
    logic [VAR_COUNT-1:0] hiSet;
    logic [VAR_COUNT-1:0] loSet;
    logic [VAR_COUNT-1:0] towardSet;
    logic [VAR_COUNT-1:0] awaySet;

    for (genvar b = 0; b < VAR_COUNT; b++) begin : gBit
      localparam int NB = neighbourIdx(i, b);
      if (((i >> b) & 1) == 0) begin : gHi
        assign hiSet[b] = graphIn[NB];
        assign loSet[b] = 1'b0;
      end else begin : gLo
        assign hiSet[b] = 1'b0;
        assign loSet[b] = graphIn[NB];
      end
    end

    // UP mode is the DOWN rule with the roles of hi and lo swapped.
    assign towardSet     = dirUp ? loSet : hiSet;
    assign awaySet       = dirUp ? hiSet : loSet;
    assign removeMask[i] = graphIn[i] & $onehot(towardSet) & ~(|awaySet);
  end

  assign graphOut = graphIn & ~removeMask;
  assign changed  = |removeMask;

endmodule

// File: rtl/iterative_leaf_eliminator.sv
// Iterates leaf elimination on a lattice node mask until a fixpoint or
// MAX_ITER passes, with valid/ready handshakes on input and output.
module iterative_leaf_eliminator
  import leaf_elim_pkg::*;
#(
  parameter int VAR_COUNT = 7,
  parameter int MAX_ITER  = 64,
  localparam int W        = 2 ** VAR_COUNT,
  localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_graph,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_graph,
  output logic [ITER_W-1:0] out_iters,
  output logic              out_converged
);

  elimState_t        state;
  elimState_t        stateNext;
  logic [W-1:0]      graphReg;
  logic [W-1:0]      passGraph;
  logic [1:0]        modeReg;
  logic [ITER_W-1:0] iterCount;
  logic [ITER_W-1:0] nextCount;
  logic              prevStable;
  logic              converged;
  logic              passChanged;
  logic              isAlt;
  logic              dirUp;
  logic              stable;
  logic              lastPass;

  // Reserved mode 3 falls through to DOWN because it matches neither UP nor ALT.
  assign isAlt     = (modeReg == MODE_ALT);
  assign dirUp     = (modeReg == MODE_UP) || (isAlt && iterCount[0]);
  assign nextCount = iterCount + ITER_W'(1);
  assign stable    = isAlt ? (!passChanged && prevStable) : !passChanged;
  assign lastPass  = (nextCount == ITER_W'(MAX_ITER));

  leaf_elim_pass #(
    .VAR_COUNT (VAR_COUNT)
  ) uPass (
    .graphIn  (graphReg),
    .dirUp    (dirUp),
    .graphOut (passGraph),
    .changed  (passChanged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = RUN;
      end
      RUN: begin
        if (stable || lastPass) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: the result registers simply freeze once the FSM reaches DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      graphReg   <= '0;
      modeReg    <= '0;
      iterCount  <= '0;
      prevStable <= 1'b0;
      converged  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            graphReg   <= in_graph;
            modeReg    <= in_mode;
            iterCount  <= '0;
            prevStable <= 1'b0;
            converged  <= 1'b0;
          end
        end
        RUN: begin
          graphReg   <= passGraph;
          iterCount  <= nextCount;
          prevStable <= !passChanged;
          converged  <= stable;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_graph     = graphReg;
  assign out_iters     = iterCount;
  assign out_converged = converged;

endmodule
